// File: rtl/uart_tx_arbiter_if.sv
// Bus-side signal bundle for uart_tx_arbiter: CPU write strobes and data in,
// status, serial lines and interrupt out.
interface uart_tx_arbiter_if;
   logic       wr0;
   logic       wr1;
   logic [7:0] din;
   logic       ie_wr;
   logic [1:0] ie_din;
   logic [3:0] status;
   logic       txd0;
   logic       txd1;
   logic       irq_n;

   modport master (
      output wr0, wr1, din, ie_wr, ie_din,
      input  status, txd0, txd1, irq_n
   );

   modport slave (
      input  wr0, wr1, din, ie_wr, ie_din,
      output status, txd0, txd1, irq_n
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Two-channel UART transmitter sharing one 8N1 shifter, granted per frame round-robin.
// Optional interrupt logic is compiled in when UART_ARB_IRQ_EN is defined.
module uart_tx_arbiter #(
   parameter int BAUD_DIV = 208,
   parameter int DIV_W    = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   uart_tx_arbiter_if.slave  io_bus
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   localparam logic [DIV_W-1:0] LP_BAUD_LAST = DIV_W'(BAUD_DIV - 1);

   state_t           r_state;
   state_t           w_nextState;
   logic [DIV_W-1:0] r_baud;
   logic [2:0]       r_bitIdx;
   logic [7:0]       r_shift;
   logic [7:0]       r_hold0;
   logic [7:0]       r_hold1;
   logic             r_full0;
   logic             r_full1;
   logic             r_busy;
   logic             r_act;
   logic             r_last;
   logic             r_txd0;
   logic             r_txd1;

   logic             w_baudEnd;
   logic             w_load;
   logic             w_grant;
   logic             w_nextLine;
   logic             w_nextAct;
   logic             w_clr0;
   logic             w_clr1;
   logic             w_acc0;
   logic             w_acc1;

   assign w_baudEnd = (r_baud == LP_BAUD_LAST);

   always_comb begin
      w_nextState = r_state;
      w_load      = 1'b0;
      w_grant     = 1'b0;
      w_nextLine  = 1'b1;
      case (r_state)
         S_IDLE: begin
            if (r_full0 | r_full1) begin
               w_load      = 1'b1;
               w_grant     = (r_full0 & r_full1) ? ~r_last : r_full1;
               w_nextState = S_START;
               w_nextLine  = 1'b0;
            end
         end
         S_START: begin
            w_nextLine = 1'b0;
            if (w_baudEnd) begin
               w_nextState = S_DATA;
               w_nextLine  = r_shift[0];
            end
         end
         S_DATA: begin
            w_nextLine = r_shift[r_bitIdx];
            if (w_baudEnd) begin
               if (r_bitIdx == 3'd7) begin
                  w_nextState = S_STOP;
                  w_nextLine  = 1'b1;
               end else begin
                  w_nextLine = r_shift[r_bitIdx + 3'd1];
               end
            end
         end
         S_STOP: begin
            if (w_baudEnd) w_nextState = S_IDLE;
         end
         default: w_nextState = S_IDLE;
      endcase
   end

   assign w_nextAct = w_load ? w_grant : r_act;
   assign w_clr0    = w_load & ~w_grant;
   assign w_clr1    = w_load & w_grant;
   // A write is accepted into an empty holding register, or into one being drained this cycle.
   assign w_acc0    = io_bus.wr0 & (~r_full0 | w_clr0);
   assign w_acc1    = io_bus.wr1 & (~r_full1 | w_clr1);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_nextState;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_baud   <= '0;
         r_bitIdx <= '0;
         r_shift  <= '0;
         r_busy   <= 1'b0;
         r_act    <= 1'b0;
         r_last   <= 1'b1;
         r_txd0   <= 1'b1;
         r_txd1   <= 1'b1;
      end else begin
         if (w_load) begin
            r_shift <= w_grant ? r_hold1 : r_hold0;
            r_act   <= w_grant;
            r_last  <= w_grant;
            r_busy  <= 1'b1;
            r_baud  <= '0;
         end else if (r_state != S_IDLE) begin
            r_baud <= w_baudEnd ? '0 : r_baud + DIV_W'(1);
         end
         if (r_state == S_START && w_baudEnd)     r_bitIdx <= '0;
         else if (r_state == S_DATA && w_baudEnd) r_bitIdx <= r_bitIdx + 3'd1;
         if (r_state == S_STOP && w_baudEnd) r_busy <= 1'b0;
         // Only the channel owning the frame sees the line; the other idles high.
         r_txd0 <= w_nextAct ? 1'b1 : w_nextLine;
         r_txd1 <= w_nextAct ? w_nextLine : 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_hold0 <= '0;
         r_hold1 <= '0;
         r_full0 <= 1'b0;
         r_full1 <= 1'b0;
      end else begin
         if (w_acc0) begin
            r_hold0 <= io_bus.din;
            r_full0 <= 1'b1;
         end else if (w_clr0) begin
            r_full0 <= 1'b0;
         end
         if (w_acc1) begin
            r_hold1 <= io_bus.din;
            r_full1 <= 1'b1;
         end else if (w_clr1) begin
            r_full1 <= 1'b0;
         end
      end
   end

   assign io_bus.status = {r_act, r_busy, r_full1, r_full0};
   assign io_bus.txd0   = r_txd0;
   assign io_bus.txd1   = r_txd1;

`ifdef UART_ARB_IRQ_EN
   logic [1:0] r_ie;
   logic       r_irqN;

   // Interrupt requests a refill whenever an enabled holding register is empty.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ie   <= 2'b00;
         r_irqN <= 1'b1;
      end else begin
         if (io_bus.ie_wr) r_ie <= io_bus.ie_din;
         r_irqN <= ~((r_ie[0] & ~r_full0) | (r_ie[1] & ~r_full1));
      end
   end

   assign io_bus.irq_n = r_irqN;
`else
   logic w_unusedIe;
   assign w_unusedIe   = ^{io_bus.ie_wr, io_bus.ie_din};
   assign io_bus.irq_n = 1'b1;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed corner sequences,
// and random traffic checked cycle by cycle against a frame-timing reference model.
module tb_uart_tx_arbiter;

   localparam int B = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   uart_tx_arbiter_if bus();

   uart_tx_arbiter #(.BAUD_DIV(B), .DIV_W(8)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus)
   );

   always #5 clk = ~clk;

   int testsRun    = 0;
   int testsFailed = 0;

   typedef struct {
      int         ch;
      logic [7:0] data;
   } frame_t;

   typedef struct {
      bit         wr0;
      bit         wr1;
      logic [7:0] din;
      int         waitCyc;
      logic [3:0] expStatus;
   } vec_t;

   // Reference model: frame start/end times, holding registers and expected frame order.
   int         n;
   int         fs;
   int         fe;
   int         mAct;
   int         mLast;
   logic [7:0] fb;
   bit         mFull[2];
   logic [7:0] mHold[2];
   bit         mIe[2];
   bit         mIrqN;
   frame_t     expQ[$];

   bit         rxOn[2];
   int         rxCnt[2];
   logic [7:0] rxByte[2];
   int         recvCh[$];
   logic [7:0] recvData[$];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      testsRun++;
      if (actual !== required) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, required, $time);
      end
   endtask

   task automatic modelStep();
      int g;
      if (rst) begin
         n = 0; fs = -1000; fe = -1; mAct = 0; mLast = 1; fb = '0;
         mFull = '{0, 0}; mHold = '{8'h00, 8'h00}; mIe = '{0, 0}; mIrqN = 1'b1;
         expQ.delete();
      end else begin
         n++;
`ifdef UART_ARB_IRQ_EN
         mIrqN = !((mIe[0] && !mFull[0]) || (mIe[1] && !mFull[1]));
         if (bus.ie_wr) begin
            mIe[0] = bus.ie_din[0];
            mIe[1] = bus.ie_din[1];
         end
`endif
         if (n > fe && (mFull[0] || mFull[1])) begin
            g = (mFull[0] && mFull[1]) ? 1 - mLast : (mFull[0] ? 0 : 1);
            fs = n; fe = n + 10 * B; fb = mHold[g];
            mAct = g; mLast = g; mFull[g] = 0;
            expQ.push_back('{ch: g, data: mHold[g]});
         end
         if (bus.wr0 && !mFull[0]) begin mFull[0] = 1; mHold[0] = bus.din; end
         if (bus.wr1 && !mFull[1]) begin mFull[1] = 1; mHold[1] = bus.din; end
      end
   endtask

   function automatic logic [31:0] modelOut();
      logic       line;
      int         j;
      logic [3:0] st;
      line = 1'b1;
      if (n >= fs && n < fe) begin
         j = (n - fs) / B;
         if (j == 0)      line = 1'b0;
         else if (j <= 8) line = fb[j-1];
      end
      st = {1'(mAct), (n < fe), mFull[1], mFull[0]};
      return {25'd0, mIrqN, (mAct == 1) ? line : 1'b1, (mAct == 0) ? line : 1'b1, st};
   endfunction

   task automatic recordFrame(input int c, input logic [7:0] data);
      frame_t f;
      recvCh.push_back(c);
      recvData.push_back(data);
      if (expQ.size() == 0) begin
         checkOutput("frame_expected", expQ.size(), 1);
      end else begin
         f = expQ.pop_front();
         checkOutput("frame_ch", c, f.ch);
         checkOutput("frame_data", data, f.data);
      end
   endtask

   task automatic rxStep();
      logic txd;
      for (int c = 0; c < 2; c++) begin
         txd = (c == 0) ? bus.txd0 : bus.txd1;
         if (rst) begin
            rxOn[c] = 0;
         end else if (!rxOn[c]) begin
            if (txd == 1'b0) begin
               rxOn[c] = 1; rxCnt[c] = 0;
            end
         end else begin
            rxCnt[c]++;
            if (rxCnt[c] % B == B / 2 && rxCnt[c] / B >= 1 && rxCnt[c] / B <= 8)
               rxByte[c][rxCnt[c] / B - 1] = txd;
            if (rxCnt[c] == 9 * B + B / 2) begin
               checkOutput("stop_bit", txd, 1);
               recordFrame(c, rxByte[c]);
            end
            if (rxCnt[c] == 10 * B - 1) rxOn[c] = 0;
         end
      end
   endtask

   task automatic cycleCheck();
      if (!rst)
         checkOutput("cycle", {25'd0, bus.irq_n, bus.txd1, bus.txd0, bus.status}, modelOut());
   endtask

   always @(posedge clk or posedge rst) modelStep();

   always @(negedge clk) begin
      cycleCheck();
      rxStep();
   end

   // Caller sits on a negedge; the write lands on the following posedge.
   task automatic applyStimulus(input bit w0, input bit w1, input logic [7:0] d);
      bus.wr0 = w0; bus.wr1 = w1; bus.din = d;
      @(negedge clk);
      bus.wr0 = 1'b0; bus.wr1 = 1'b0;
   endtask

   task automatic resetDut();
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic waitIdle(input int maxCyc);
      for (int i = 0; i < maxCyc; i++) begin
         @(negedge clk);
         if (bus.status[2:0] == 3'b000) break;
      end
      checkOutput("wait_idle", bus.status[2:0], 0);
   endtask

   task automatic clearRecv();
      recvCh.delete();
      recvData.delete();
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      vec_t       vecs[15];
      logic [9:0] pat;
      int         expCh[5];
      logic [7:0] expData[5];

      vecs[0]  = '{1, 1, 8'hA1,  0, 4'b0011};
      vecs[1]  = '{0, 0, 8'h00,  0, 4'b0110};
      vecs[2]  = '{0, 0, 8'h00, 38, 4'b0110};
      vecs[3]  = '{0, 0, 8'h00,  0, 4'b0010};
      vecs[4]  = '{0, 0, 8'h00,  0, 4'b1100};
      vecs[5]  = '{1, 0, 8'h11,  0, 4'b1101};
      vecs[6]  = '{1, 0, 8'h22,  0, 4'b1101};
      vecs[7]  = '{0, 0, 8'h00, 38, 4'b0100};
      vecs[8]  = '{0, 0, 8'h00, 39, 4'b0000};
      vecs[9]  = '{1, 0, 8'h5A,  0, 4'b0001};
      vecs[10] = '{1, 0, 8'hC3,  0, 4'b0101};
      vecs[11] = '{0, 0, 8'h00, 38, 4'b0101};
      vecs[12] = '{0, 0, 8'h00,  0, 4'b0001};
      vecs[13] = '{0, 0, 8'h00,  0, 4'b0100};
      vecs[14] = '{0, 0, 8'h00, 39, 4'b0000};
      expCh   = '{0, 1, 0, 0, 0};
      expData = '{8'hA1, 8'hA1, 8'h11, 8'h5A, 8'hC3};

      bus.wr0 = 1'b0; bus.wr1 = 1'b0; bus.din = '0; bus.ie_wr = 1'b0; bus.ie_din = '0;

      repeat (2) @(negedge clk);
      checkOutput("reset_status", bus.status, 4'b0000);
      checkOutput("reset_txd0", bus.txd0, 1);
      checkOutput("reset_txd1", bus.txd1, 1);
      checkOutput("reset_irq_n", bus.irq_n, 1);
      rst = 1'b0;

      $display("[TB] single frame 0x55 on channel 0");
      pat = 10'b1010101010;
      applyStimulus(1, 0, 8'h55);
      for (int i = 0; i < 10 * B; i++) begin
         @(negedge clk);
         checkOutput($sformatf("t1_txd0_c%0d", i), bus.txd0, pat[i / B]);
         checkOutput($sformatf("t1_txd1_c%0d", i), bus.txd1, 1);
      end
      @(negedge clk);
      checkOutput("t1_idle_status", bus.status, 4'b0000);

      $display("[TB] vector table");
      resetDut();
      clearRecv();
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].wr0, vecs[i].wr1, vecs[i].din);
         repeat (vecs[i].waitCyc) @(negedge clk);
         checkOutput($sformatf("vec%0d_status", i), bus.status, vecs[i].expStatus);
      end
      repeat (2) @(negedge clk);
      checkOutput("vec_frame_count", recvCh.size(), 5);
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("vec_rx%0d_ch", i), recvCh[i], expCh[i]);
         checkOutput($sformatf("vec_rx%0d_data", i), recvData[i], expData[i]);
      end

      $display("[TB] fairness with continuous refill");
      resetDut();
      clearRecv();
      for (int i = 0; i < 250; i++) begin
         bus.wr0 = 1'b1; bus.wr1 = 1'b1; bus.din = 8'(i * 7 + 3);
         @(negedge clk);
      end
      bus.wr0 = 1'b0; bus.wr1 = 1'b0;
      waitIdle(1000);
      repeat (2) @(negedge clk);
      checkOutput("fair_count", recvCh.size() >= 6, 1);
      for (int i = 0; i < 6; i++)
         checkOutput($sformatf("fair_order%0d", i), recvCh[i], i % 2);

      $display("[TB] reset in the middle of a frame");
      resetDut();
      applyStimulus(1, 0, 8'hF0);
      repeat (17) @(negedge clk);
      checkOutput("t5_txd0_bit3", bus.txd0, 0);
      #2 rst = 1'b1;
      #1;
      checkOutput("t5_async_txd0", bus.txd0, 1);
      checkOutput("t5_async_txd1", bus.txd1, 1);
      checkOutput("t5_async_status", bus.status, 4'b0000);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clearRecv();
      applyStimulus(0, 1, 8'h96);
      waitIdle(100);
      repeat (2) @(negedge clk);
      checkOutput("t5_frame_count", recvCh.size(), 1);
      checkOutput("t5_frame_ch", recvCh[0], 1);
      checkOutput("t5_frame_data", recvData[0], 8'h96);

      $display("[TB] interrupt output");
      resetDut();
`ifdef UART_ARB_IRQ_EN
      bus.ie_wr = 1'b1; bus.ie_din = 2'b01;
      @(negedge clk);
      bus.ie_wr = 1'b0;
      @(negedge clk);
      checkOutput("t6_irq_enabled", bus.irq_n, 0);
      applyStimulus(1, 0, 8'h42);
      checkOutput("t6_irq_write_edge", bus.irq_n, 0);
      @(negedge clk);
      checkOutput("t6_irq_full", bus.irq_n, 1);
      @(negedge clk);
      checkOutput("t6_irq_loaded", bus.irq_n, 0);
`else
      applyStimulus(1, 1, 8'h42);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("t6_irq_const%0d", i), bus.irq_n, 1);
         @(negedge clk);
      end
`endif
      waitIdle(200);

      $display("[TB] random traffic");
      resetDut();
      for (int i = 0; i < 3000; i++) begin
         bus.wr0    = ($urandom_range(0, 15) == 0);
         bus.wr1    = ($urandom_range(0, 15) == 0);
         bus.din    = 8'($urandom);
         bus.ie_wr  = ($urandom_range(0, 63) == 0);
         bus.ie_din = 2'($urandom);
         @(negedge clk);
      end
      bus.wr0 = 1'b0; bus.wr1 = 1'b0; bus.ie_wr = 1'b0;
      waitIdle(1000);
      repeat (2) @(negedge clk);
      checkOutput("exp_queue_empty", expQ.size(), 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
